if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a ready/valid handshake.
- Buffers the returned word and presents `pc8`/`instr` to IF/ID, or a NOP bubble while a fetch is outstanding.
- Applies D-stage branch/jump redirects while honouring the branch delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, PC fetched first after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- stall  in  1  hazard-unit stall; IF/ID En is driven as !stall, so IF/ID holds while stall=1
- redirect  in  1  branch/jump taken by the instruction in D
- redirect_pc  in  32  redirect target (word aligned)
- im_req  out  1  memory request valid
- im_addr  out  32  request address (= pc)
- im_ready  in  1  memory accepts request this cycle
- im_rvalid  in  1  read data valid
- im_rdata  in  32  read data
- fetch_valid  out  1  instr/pc8 hold a real fetched instruction
- instr  out  32  instruction to IF/ID; 0 (NOP) when fetch_valid=0
- pc8  out  32  pc+8 when fetch_valid=1, else 0

Behaviour:
- Registers:
  - `pc`: address being fetched / next to deliver.
  - `state`: one of S_REQ, S_WAIT, S_FULL.
  - `ibuf` (32): captured instruction word.
  - `rpend` (1) and `rpc` (32): latched redirect.
- Reset (reset=0, async): pc=RESET_PC, state=S_REQ, ibuf=0, rpend=0, rpc=0.
  - Outputs during reset: im_req=0, fetch_valid=0, instr=0, pc8=0.
- S_REQ: im_req=1, im_addr=pc. Advance to S_WAIT on im_ready=1; otherwise stay, holding address stable.
- S_WAIT: im_req=0. im_rvalid=1 → ibuf<=im_rdata, go to S_FULL. im_rvalid is never expected in the same cycle as im_ready.
- im_rvalid is ignored outside S_WAIT.
- S_FULL: fetch_valid=1, instr=ibuf, pc8=pc+8 (32-bit, modulo 2^32).
- Handoff = rising edge with state=S_FULL and stall=0. At handoff:
  - state<=S_REQ.
  - pc<=redirect_pc if redirect=1; else rpc if rpend=1; else pc+4.
  - rpend<=0.
  - The delivered word is the delay slot of any pending or current redirect.
- Redirect sampling:
  - redirect is honoured only when stall=0; with stall=1 it is ignored because D re-asserts it.
  - redirect=1, stall=0, no handoff (state≠S_FULL): rpend<=1, rpc<=redirect_pc. The in-flight fetch is the delay slot and is NOT killed.
  - redirect=1 while rpend=1: rpc is overwritten, newest wins. This cannot occur in legal code and the bench flags it.
- Stall in S_FULL: outputs held, no new request.
- Stall in S_REQ/S_WAIT: the handshake proceeds normally; stall only blocks handoff.
- Throughput with zero-wait memory (ready in S_REQ cycle, rvalid next cycle): 1 instruction per 3 cycles.
  - First fetch_valid occurs 2 edges after reset release.
- Bubbles: whenever fetch_valid=0, IF/ID captures instr=0/pc8=0 (NOP) on non-stalled edges. This is architecturally invisible.
- Memory shares reset. A response for a request issued before reset assertion arrives either in a state other than S_WAIT (ignored) or during reset (ignored).

Test Plan:
1. Reset release, zero-wait memory returning addr-derived data (e.g. addr>>2):
   - im_addr sequence 0x3000, 0x3004, 0x3008.
   - instr 0xC00 with pc8=0x3008, then 0xC01 with pc8=0x300C.
   - fetch_valid pattern 0,0,1 repeating.
2. stall=1 for 4 cycles while in S_FULL (instr=0xC01):
   - instr/pc8 constant, im_req=0.
   - After stall drops, next im_addr=0x3008.
3. redirect=1, redirect_pc=0x3100 on the handoff edge of delay slot 0x3004:
   - Next im_addr=0x3100; delivered order 0x3004 word, then 0x3100 word.
4. 3-cycle memory latency; redirect=1 (target 0x3200) while delay slot 0x3004 is in S_WAIT:
   - Bubble instr=0/pc8=0 while waiting.
   - Delay-slot word delivered, then im_addr=0x3200; rpend clears.
5. redirect=1 with stall=1 for one cycle, then redirect=0:
   - No rpend set; fetch continues at pc+4.
6. Assert reset in S_WAIT, deassert 2 cycles later; memory fires im_rvalid in S_REQ after release:
   - Outputs zero immediately on assertion.
   - Restart at 0x3000; stray rvalid ignored; ibuf unchanged.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
//
// Handshake: a request transfers on a rising edge where im_req=1 and
// im_ready=1. The master holds im_addr stable while im_req=1 and im_ready=0.
// The read word returns on a later edge where im_rvalid=1. It never returns
// in the same cycle as the accepting im_ready. The master has only one
// request outstanding at a time, and it ignores im_rvalid unless it is
// waiting for a response.
interface if_fetch_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_rvalid,
    output im_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage of a 5-stage MIPS pipeline.
// Owns the PC and fetches one word at a time from instruction memory.
// Presents the word together with pc+8 to the IF/ID register, and presents
// a NOP bubble while a fetch is still outstanding. A branch/jump redirect
// from D is applied after the delay-slot word has been handed off.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,        // active-low, asynchronous
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_fetch_if.master  im,
  output logic        fetch_valid,
  output logic [31:0] instr,
  output logic [31:0] pc8,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_rpend_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] ibuf_q,  ibuf_d;
  logic        rpend_q, rpend_d;
  logic [31:0] rpc_q,   rpc_d;

  logic        handoff;
  logic        redirect_take;

  // A word leaves for IF/ID only when it is buffered and IF/ID is enabled.
  assign handoff       = (state_q == S_FULL) && !stall;
  // D re-asserts a stalled redirect, so only an unstalled one is sampled.
  assign redirect_take = redirect && !stall;

  // Next-state logic for the fetch FSM, the PC and the latched redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ibuf_d  = ibuf_q;
    rpend_d = rpend_q;
    rpc_d   = rpc_q;

    case (state_q)
      S_REQ: begin
        if (im.im_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (im.im_rvalid) begin
          ibuf_d  = im.im_rdata;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (handoff) begin
          state_d = S_REQ;
          rpend_d = 1'b0;
          // The word handed off now is the delay slot of any redirect.
          // The redirect therefore takes effect on the very next fetch.
          if (redirect) begin
            pc_d = redirect_pc;
          end else if (rpend_q) begin
            pc_d = rpc_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect seen while the delay slot is still in flight is remembered.
    // That fetch is not killed. The newest target wins if two arrive.
    if (redirect_take && (state_q != S_FULL)) begin
      rpend_d = 1'b1;
      rpc_d   = redirect_pc;
    end
  end

  // State registers; memory shares this reset, so nothing survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ibuf_q  <= 32'd0;
      rpend_q <= 1'b0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
      rpend_q <= rpend_d;
      rpc_q   <= rpc_d;
    end
  end

  // The request is gated by reset so that im_req drops as soon as reset asserts.
  assign im.im_req  = reset && (state_q == S_REQ);
  assign im.im_addr = pc_q;

  assign fetch_valid = (state_q == S_FULL);
  assign instr       = fetch_valid ? ibuf_q : 32'd0;
  assign pc8         = fetch_valid ? (pc_q + 32'd8) : 32'd0;

  assign dbg_state_o = state_q;
  assign dbg_rpend_o = rpend_q;

endmodule
